mem_rd_streamer: RTL and testbench
==================================

MEM_RD_STREAMER -- requirements
Module: mem_rd_streamer

Interface
REQ-001 Parameter WIDTH, default 64, memory word and stream data width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4, output buffer entries (fixed at 4 for this release).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock shared with the memory.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 base_addr  input  32  first word address of the burst; captured on accepted start.
REQ-008 length  input  16  number of words in the burst; captured on accepted start.
REQ-009 busy  output  1  high from the cycle after an accepted start until the done cycle inclusive.
REQ-010 done  output  1  one-cycle pulse at burst completion.
REQ-011 mem_write_en  output  1  memory write enable; held 0 at all times.
REQ-012 mem_addr  output  32  memory word address, registered.
REQ-013 mem_data_out  input  WIDTH  memory read data; holds mem[addr] one cycle after addr is presented.
REQ-014 m_valid  output  1  stream data valid.
REQ-015 m_ready  input  1  downstream accept.
REQ-016 m_data  output  WIDTH  stream data, driven from the FIFO head.
REQ-017 m_last  output  1  high with the final beat of the burst.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start with length!=0; IDLE->DONE on start with length==0; RUN->DONE on the handshake of beat length-1; DONE->IDLE unconditionally after one cycle.
REQ-019 done SHALL be 1 exactly in the DONE state.
REQ-020 A start asserted outside IDLE SHALL be ignored, with no effect on the current burst.
REQ-021 A read issue in cycle t SHALL drive mem_addr=base_addr+i during cycle t; the word SHALL be pushed into the FIFO at the end of cycle t+1 from mem_data_out.
REQ-022 An in-flight valid bit SHALL track each issue, because mem_data_out changes every cycle and is not self-qualified.
REQ-023 An issue SHALL occur in RUN when issued count < length and (fifo_count + inflight) < FIFO_DEPTH; this condition guarantees the FIFO never overflows.
REQ-024 The address SHALL increment by 1 per issue modulo 2^32; wrap from 0xFFFFFFFF to 0 SHALL be silent.
REQ-025 Timing with m_ready=1: start accepted in cycle 0, first issue in cycle 1, m_valid=1 in cycle 3, then one beat per cycle sustained.
REQ-026 A beat SHALL transfer when m_valid and m_ready are both 1; m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-027 A push and a pop in the same cycle SHALL leave fifo_count unchanged; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 m_last SHALL be 1 only on the beat whose index is length-1.
REQ-029 m_valid SHALL never assert in IDLE or DONE.
REQ-030 Words are delivered in address order with no loss or duplication under any m_ready pattern.

Reset
REQ-031 When rst_n=0: state=IDLE, busy=0, done=0, m_valid=0, m_last=0, mem_addr=0, mem_write_en=0, FIFO empty, in-flight and counters cleared.
REQ-032 Reset asserted mid-burst SHALL abort the burst; no beat, no done pulse, and no memory write SHALL follow.
REQ-033 After rst_n deasserts, the next start SHALL behave identically to a start after power-up.

Verification
REQ-034 Memory preloaded with mem[k]=k; start with base=2048, length=4, m_ready=1 -> beats 2048..2051 in cycles 3..6, m_last on 2051, done in cycle 7.
REQ-035 length=0 start -> done pulse in the next cycle, no issue, m_valid stays 0.
REQ-036 base=2048, length=16, m_ready toggling 1/0 each cycle plus a 10-cycle stall at beat 5 -> all 16 words in order, FIFO count never above 4, data stable during stalls.
REQ-037 base=0xFFFFFFFE, length=4 -> mem_addr sequence FFFFFFFE, FFFFFFFF, 0, 1; four beats delivered.
REQ-038 start pulsed again during a length=8 burst -> ignored, exactly 8 beats and one done pulse.
REQ-039 rst_n pulled low after beat 3 of a length=8 burst -> all outputs at reset values immediately; a fresh length=2 burst then delivers 2 correct beats.

Source files
------------

// File: rtl/mem_rd_streamer.sv
// mem_rd_streamer
//   Reads a burst of consecutive words from a synchronous memory and
//   streams them out on a valid/ready interface through a small FIFO.
//   The memory returns data one cycle after the address is presented.
//   That data is not self-qualified, so a single in-flight bit marks
//   which cycles carry a word to push.
//   A read is issued only when the FIFO plus the in-flight word still
//   has room. Because of this the FIFO can never overflow, whatever
//   pattern the downstream ready signal follows.
//
// Ports
//   clk, rst_n       clock shared with the memory; async active-low reset
//   start            one-cycle burst request, honoured only when idle
//   base_addr        first word address of the burst
//   length           number of words in the burst (0 allowed)
//   busy             high from the cycle after the start until done inclusive
//   done             one-cycle completion pulse
//   mem_write_en     memory write enable, tied low
//   mem_addr         registered memory word address
//   mem_data_out     memory read data (mem[addr] one cycle after addr)
//   m_valid/m_ready  stream handshake
//   m_data           stream data from the FIFO head
//   m_last           marks the final beat of the burst
module mem_rd_streamer #(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [15:0]      length,
  output logic             busy,
  output logic             done,
  output logic             mem_write_en,
  output logic [31:0]      mem_addr,
  input  logic [WIDTH-1:0] mem_data_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      len_q;
  logic [15:0]      issued_q;
  logic [15:0]      popped_q;
  logic [31:0]      addr_q;
  logic             inflight_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] fifo_q [FIFO_DEPTH];

  logic issue_d;
  logic push_d;
  logic pop_d;
  logic last_beat_d;

  // Pointer advance with an explicit wrap, so depths that are not a
  // power of two also wrap correctly.
  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The in-flight word is counted as occupied space, so the returning
  // word always finds room in the FIFO.
  always_comb begin
    issue_d     = (state_q == RUN) && (issued_q < len_q) &&
                  ((int'(count_q) + int'(inflight_q)) < FIFO_DEPTH);
    push_d      = inflight_q;
    pop_d       = m_valid && m_ready;
    last_beat_d = (popped_q == (len_q - 16'd1));
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_write_en = 1'b0;
  assign mem_addr     = addr_q;
  assign m_valid      = (state_q == RUN) && (count_q != '0);
  assign m_data       = fifo_q[rd_ptr_q];
  assign m_last       = m_valid && last_beat_d;

  // The FIFO storage needs no reset: the occupancy count qualifies it.
  always_ff @(posedge clk) begin
    if (push_d) begin
      fifo_q[wr_ptr_q] <= mem_data_out;
    end
  end

  // Burst control FSM together with the address, counter and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= issue_d;

      if (push_d) begin
        wr_ptr_q <= ptrInc(wr_ptr_q);
      end
      if (pop_d) begin
        rd_ptr_q <= ptrInc(rd_ptr_q);
      end
      if (push_d && !pop_d) begin
        count_q <= count_q + CW'(1);
      end else if (!push_d && pop_d) begin
        count_q <= count_q - CW'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q    <= length;
            addr_q   <= base_addr;
            issued_q <= '0;
            popped_q <= '0;
            busy_q   <= 1'b1;
            if (length == 16'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          // The address wraps silently past 0xFFFFFFFF.
          if (issue_d) begin
            addr_q   <= addr_q + 32'd1;
            issued_q <= issued_q + 16'd1;
          end
          if (pop_d) begin
            popped_q <= popped_q + 16'd1;
            if (last_beat_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rd_streamer.sv
// tb_mem_rd_streamer
//   Drives mem_rd_streamer against a synchronous memory whose word k holds
//   {~k, k}. The low half is the address, so the upper bits are exercised
//   too. A behavioural model builds, at each accepted start, the queue of
//   words the burst must deliver. It then follows busy/done and the stream
//   beat by beat on every falling edge.
module tb_mem_rd_streamer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_data_out;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;

  int checks   = 0;
  int failures = 0;

  mem_rd_streamer #(.WIDTH(64), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] memWord(input logic [31:0] k);
    return {~k, k};
  endfunction

  // Synchronous read memory: the data follows the address by one cycle.
  always @(posedge clk) begin
    mem_data_out <= memWord(mem_addr);
  end

  task automatic checkOutput(input bit ok, input string name,
                             input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state and the record of each observed burst.
  logic [63:0] expQ[$];
  bit          busyNow = 1'b0;
  bit          doneNow = 1'b0;
  bit          stallPrev = 1'b0;
  logic [63:0] prevData;
  bit          prevLast;
  int          cycleCount = 0;
  int          acceptCycle = -100;
  int          doneCycle = -100;
  int          donePulses = 0;
  logic [63:0] beatData[$];
  int          beatCycles[$];

  // Ready pattern selector: 0 always, 1 toggle, 2 random, 3 toggle plus a
  // 10-cycle stall once five beats have gone.
  int readyMode = 0;
  int stallLeft = 0;
  bit stallDone = 1'b0;

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: m_ready = 1'b1;
      1: m_ready = !m_ready;
      2: m_ready = 1'($urandom_range(0, 1));
      default: begin
        if (stallLeft > 0) begin
          m_ready = 1'b0;
          stallLeft--;
        end else if (!stallDone && beatData.size() == 5) begin
          stallDone = 1'b1;
          stallLeft = 9;
          m_ready   = 1'b0;
        end else begin
          m_ready = !m_ready;
        end
      end
    endcase
  end

  // Compare process: checks the DUT against the model on every falling
  // edge, then advances the model to the next cycle.
  always @(negedge clk) begin
    bit lastHs;
    bit nextBusy;
    bit nextDone;
    if (!rst_n) begin
      checkOutput(busy == 1'b0 && done == 1'b0 && m_valid == 1'b0 && m_last == 1'b0,
                  "reset_ctrl", {busy, done, m_valid, m_last}, 0);
      checkOutput(mem_addr == 32'd0 && mem_write_en == 1'b0, "reset_mem",
                  {mem_write_en, mem_addr}, 0);
      expQ.delete();
      busyNow   = 1'b0;
      doneNow   = 1'b0;
      stallPrev = 1'b0;
    end else begin
      cycleCount++;
      lastHs = 1'b0;
      checkOutput(done == doneNow, "done", done, doneNow);
      checkOutput(busy == busyNow, "busy", busy, busyNow);
      checkOutput(mem_write_en == 1'b0, "write_en", mem_write_en, 0);
      if (done) donePulses++;
      if (m_valid) begin
        if (!busyNow || doneNow || expQ.size() == 0 || cycleCount < acceptCycle + 3) begin
          checkOutput(1'b0, "spurious_valid", m_valid, 0);
        end else begin
          checkOutput(m_data == expQ[0], "data", m_data, expQ[0]);
          checkOutput(m_last == (expQ.size() == 1), "last", m_last, expQ.size() == 1);
          if (stallPrev) begin
            checkOutput(m_data == prevData && m_last == prevLast, "stall_stable",
                        m_data, prevData);
          end
          if (m_ready) begin
            beatData.push_back(m_data);
            beatCycles.push_back(cycleCount);
            void'(expQ.pop_front());
            lastHs = (expQ.size() == 0);
          end
        end
      end else begin
        checkOutput(m_last == 1'b0, "last_idle", m_last, 0);
        if (stallPrev) checkOutput(1'b0, "valid_dropped", m_valid, 1);
      end
      stallPrev = m_valid && !m_ready;
      prevData  = m_data;
      prevLast  = m_last;

      nextBusy = busyNow;
      nextDone = 1'b0;
      if (lastHs) begin
        nextDone = 1'b1;
      end else if (doneNow) begin
        nextBusy = 1'b0;
      end else if (!busyNow && start) begin
        expQ.delete();
        for (int i = 0; i < int'(length); i++) expQ.push_back(memWord(base_addr + 32'(i)));
        acceptCycle = cycleCount;
        nextBusy    = 1'b1;
        nextDone    = (length == 16'd0);
      end
      if (nextDone) doneCycle = cycleCount + 1;
      busyNow = nextBusy;
      doneNow = nextDone;
    end
  end

  task automatic clearRecord();
    beatData.delete();
    beatCycles.delete();
    donePulses = 0;
    stallDone  = 1'b0;
    stallLeft  = 0;
  endtask

  task automatic applyStimulus(input logic [31:0] base, input logic [15:0] len);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = base;
    length    = len;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = $urandom;
    length    = 16'($urandom);
  endtask

  // Waits for the done pulse, optionally sprinkling start pulses that the
  // DUT must ignore while busy.
  task automatic waitDone(input bit spurious, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      start     = spurious ? ($urandom_range(0, 3) == 0) : 1'b0;
      base_addr = $urandom;
      length    = 16'($urandom_range(0, 8));
    end
    checkOutput(got, name, got, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    bit got;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Four words from 2048 with ready always high.
    readyMode = 0;
    clearRecord();
    applyStimulus(32'd2048, 16'd4);
    waitDone(1'b0, "done_timeout_basic");
    checkOutput(beatData.size() == 4, "basic_count", beatData.size(), 4);
    if (beatData.size() == 4) begin
      checkOutput(beatData[0] == 64'hFFFFF7FF_00000800, "basic_beat0", beatData[0], 64'hFFFFF7FF_00000800);
      checkOutput(beatData[3] == 64'hFFFFF7FC_00000803, "basic_beat3", beatData[3], 64'hFFFFF7FC_00000803);
      checkOutput(beatCycles[0] - acceptCycle == 3, "basic_first_cycle", beatCycles[0] - acceptCycle, 3);
      checkOutput(beatCycles[3] - acceptCycle == 6, "basic_last_cycle", beatCycles[3] - acceptCycle, 6);
    end
    checkOutput(doneCycle - acceptCycle == 7, "basic_done_cycle", doneCycle - acceptCycle, 7);

    // A zero-length burst completes at once.
    clearRecord();
    applyStimulus(32'd100, 16'd0);
    waitDone(1'b0, "done_timeout_zero");
    checkOutput(doneCycle - acceptCycle == 1, "zero_done_cycle", doneCycle - acceptCycle, 1);
    checkOutput(beatData.size() == 0, "zero_no_beats", beatData.size(), 0);

    // Sixteen words with a toggling ready and a long stall at beat 5.
    readyMode = 3;
    clearRecord();
    applyStimulus(32'd2048, 16'd16);
    waitDone(1'b0, "done_timeout_stall");
    checkOutput(beatData.size() == 16, "stall_count", beatData.size(), 16);
    if (beatData.size() == 16)
      checkOutput(beatData[15] == 64'hFFFFF7F0_0000080F, "stall_beat15", beatData[15], 64'hFFFFF7F0_0000080F);

    // The address wraps from the top of the address space to zero.
    readyMode = 2;
    clearRecord();
    applyStimulus(32'hFFFF_FFFE, 16'd4);
    waitDone(1'b0, "done_timeout_wrap");
    checkOutput(beatData.size() == 4, "wrap_count", beatData.size(), 4);
    if (beatData.size() == 4) begin
      checkOutput(beatData[1] == 64'h00000000_FFFFFFFF, "wrap_beat1", beatData[1], 64'h00000000_FFFFFFFF);
      checkOutput(beatData[2] == 64'hFFFFFFFF_00000000, "wrap_beat2", beatData[2], 64'hFFFFFFFF_00000000);
    end

    // Start pulses during a burst are ignored.
    readyMode = 1;
    clearRecord();
    applyStimulus(32'd7000, 16'd8);
    waitDone(1'b1, "done_timeout_restart");
    checkOutput(beatData.size() == 8, "restart_count", beatData.size(), 8);
    checkOutput(donePulses == 1, "restart_done_pulses", donePulses, 1);

    // Reset in the middle of a burst, then a fresh short burst.
    readyMode = 0;
    clearRecord();
    applyStimulus(32'd3000, 16'd8);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (beatData.size() >= 4) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput(got, "reset_wait_timeout", got, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput(busy == 1'b0 && done == 1'b0 && m_valid == 1'b0 && m_last == 1'b0,
                "async_reset_ctrl", {busy, done, m_valid, m_last}, 0);
    checkOutput(mem_addr == 32'd0, "async_reset_addr", mem_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearRecord();
    repeat (3) @(posedge clk);
    checkOutput(beatData.size() == 0 && donePulses == 0, "post_reset_quiet", beatData.size(), 0);
    applyStimulus(32'd500, 16'd2);
    waitDone(1'b0, "done_timeout_after_reset");
    checkOutput(beatData.size() == 2, "after_reset_count", beatData.size(), 2);
    if (beatData.size() == 2)
      checkOutput(beatData[1] == 64'hFFFFFE0A_000001F5, "after_reset_beat1", beatData[1], 64'hFFFFFE0A_000001F5);

    // Randomized bursts under random ready patterns.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] b;
      logic [15:0] l;
      b = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      l = 16'($urandom_range(0, 24));
      readyMode = $urandom_range(0, 3);
      clearRecord();
      applyStimulus(b, l);
      waitDone(1'($urandom_range(0, 1)), "done_timeout_random");
      checkOutput(beatData.size() == int'(l), "random_count", beatData.size(), l);
      checkOutput(donePulses == 1, "random_done_pulses", donePulses, 1);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
